// File: rtl/seq_adder_bcd_display.sv
// seq_adder_bcd_display: handshaked adder, sequential double-dabble BCD, multiplexed 7-segment scan
module seq_adder_bcd_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  cin,
  output logic [WIDTH-1:0]      sum,
  output logic                  cout,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  input  logic                  disp_en,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int IW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;
  if (64'(10) ** DIGITS <= (64'(1) << (WIDTH + 1)) - 64'(1)) begin : g_illegal
    $error("DIGITS too small to display the largest sum");
  end
  typedef enum logic [1:0] {IDLE, ADD, CONV, DONE} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              cin_q, cin_d, cout_q, cout_d, done_q, done_d;
  logic [WIDTH:0]    bin_q, bin_d;
  logic [BW-1:0]     scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d, blank;
  logic [3:0]        dig;
  logic              nz, bl;
  // operation FSM: capture, add, one double-dabble shift per CONV cycle, pulse done
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cin_d = cin_q;
    sum_d = sum_q;
    cout_d = cout_q;
    bin_d = bin_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    done_d = 1'b0;
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scr_q[4*i+:4] >= 4'd5 ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = ADD;
        a_d = a;
        b_d = b;
        cin_d = cin;
      end
      ADD: begin
        {cout_d, sum_d} = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
        bin_d = {cout_d, sum_d};
        scr_d = '0;
        cnt_d = '0;
        state_d = CONV;
      end
      CONV: begin
        scr_d = {adj[BW-2:0], bin_q[WIDTH]};
        bin_d = {bin_q[WIDTH-1:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) begin
          bcd_d = scr_d;
          done_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // display scan: free-running refresh divider, digit select, blanking and segment decode
  always_comb begin
    rcnt_d = rcnt_q == RW'(REFRESH_DIV - 1) ? '0 : rcnt_q + RW'(1);
    idx_d = rcnt_q != RW'(REFRESH_DIV - 1) ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1);
    nz = 1'b0;
    blank = '0;
    dig = '0;
    bl = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (bcd_q[4*i+:4] != 4'd0);
      blank[i] = BLANK_LZ != 0 && i > 0 && !nz;
    end
    for (int i = 0; i < DIGITS; i++)
      if (idx_d == IW'(i)) begin
        dig = bcd_q[4*i+:4];
        bl = blank[i];
      end
    case (dig)
      4'd0: seg_d = 7'b1000000;
      4'd1: seg_d = 7'b1111001;
      4'd2: seg_d = 7'b0100100;
      4'd3: seg_d = 7'b0110000;
      4'd4: seg_d = 7'b0011001;
      4'd5: seg_d = 7'b0010010;
      4'd6: seg_d = 7'b0000010;
      4'd7: seg_d = 7'b1111000;
      4'd8: seg_d = 7'b0000000;
      4'd9: seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
    if (bl) seg_d = 7'b1111111;
    an_d = disp_en ? ~(DIGITS'(1) << idx_d) : '1;
  end
  // state registers with asynchronous reset aborting any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      done_q <= 1'b0;
      rcnt_q <= '0;
      idx_q <= '0;
      seg_q <= '1;
      an_q <= '1;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cin_q <= cin_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      bin_q <= bin_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      done_q <= done_d;
      rcnt_q <= rcnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q <= an_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign bcd = bcd_q;
  assign done = done_q;
  assign seg_n = seg_q;
  assign an_n = an_q;
endmodule

// File: tb/tb_seq_adder_bcd_display.sv
// tb_seq_adder_bcd_display: scoreboard bench for adder, BCD conversion and display scan
module tb_seq_adder_bcd_display;
  localparam int W = 8, D = 3, R = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, disp_en = 1;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, cout, done;
  logic [W-1:0] sum;
  logic [4*D-1:0] bcd;
  logic [6:0] seg_n;
  logic [D-1:0] an_n;
  seq_adder_bcd_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(R), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sum(sum), .cout(cout), .bcd(bcd), .done(done), .disp_en(disp_en),
    .seg_n(seg_n), .an_n(an_n)
  );
  always #5 clk = ~clk;
  typedef struct {logic [W:0] s; logic [4*D-1:0] bcd; int acc;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int mon_s;
  int n_tests = 0, n_fail = 0, cyc = 0, acc_n = 0, done_n = 0, m_rc = 0, m_idx = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] to_bcd(int s);
    return {4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction
  function automatic logic [6:0] seg7(logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  function automatic logic [6:0] exp_seg(logic [11:0] eb, int idx);
    logic [11:0] hi;
    hi = eb >> (4 * idx);
    if (idx > 0 && hi == 12'd0) return 7'b1111111;
    return seg7(hi[3:0]);
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_rc <= 0;
      m_idx <= 0;
    end else if (m_rc == R - 1) begin
      m_rc <= 0;
      m_idx <= m_idx == D - 1 ? 0 : m_idx + 1;
    end else m_rc <= m_rc + 1;
  always @(negedge clk) if (rst_n) begin
    if (in_valid && in_ready) begin
      mon_s = int'(a) + int'(b) + int'(cin);
      mon_e.s = 9'(mon_s);
      mon_e.bcd = to_bcd(mon_s);
      mon_e.acc = cyc + 1;
      sb.push_back(mon_e);
      acc_n++;
    end
    if (done) begin
      done_n++;
      if (sb.size() == 0) check("spurious_done", done, 0);
      else begin
        mon_e = sb.pop_front();
        check("sum", sum, mon_e.s[7:0]);
        check("cout", cout, mon_e.s[8]);
        check("bcd", bcd, mon_e.bcd);
        check("latency", cyc - mon_e.acc, 10);
      end
    end
  end
  task automatic do_op(logic [W-1:0] ta, logic [W-1:0] tb, logic tc);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready_wait", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic scan_chk(string tag, logic [11:0] eb, int n);
    logic [D-1:0] ea;
    repeat (n) begin
      @(negedge clk);
      ea = disp_en ? ~(3'b001 << m_idx) : 3'b111;
      check({tag, "_an"}, an_n, ea);
      check({tag, "_seg"}, seg_n, exp_seg(eb, m_idx));
    end
  endtask
  int acc0, done0;
  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_ready", in_ready, 1);
    check("rst_bcd", bcd, 0);
    check("rst_sum", {cout, sum}, 0);
    check("rst_done", done, 0);
    rst_n = 1;
    @(posedge clk); #1;
    scan_chk("idle", 12'h000, 14);
    do_op(200, 100, 1);
    drain();
    check("op1_bcd", bcd, 12'h301);
    scan_chk("op1", 12'h301, 12);
    acc0 = acc_n;
    a = 255; b = 255; cin = 1; in_valid = 1;
    repeat (30) @(posedge clk); #1;
    in_valid = 0;
    drain();
    check("held_accepts", acc_n - acc0, 3);
    check("done_per_accept", done_n, acc_n);
    check("op2_bcd", bcd, 12'h511);
    do_op(7, 2, 0);
    drain();
    scan_chk("op3", 12'h009, 12);
    disp_en = 0;
    @(posedge clk); #1;
    scan_chk("dis", 12'h009, 20);
    disp_en = 1;
    @(posedge clk); #1;
    scan_chk("en", 12'h009, 12);
    do_op(100, 50, 0);
    repeat (4) @(posedge clk); #2;
    rst_n = 0;
    sb.delete();
    done0 = done_n;
    #1;
    check("arst_sum", {cout, sum}, 0);
    check("arst_bcd", bcd, 0);
    check("arst_done", done, 0);
    check("arst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", done_n, done0);
    @(posedge clk); #1;
    do_op(123, 45, 1);
    drain();
    check("op4_bcd", bcd, 12'h169);
    scan_chk("op4", 12'h169, 12);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_adder_bcd_display.md
Name: seq_adder_bcd_display

Overview:
- Parametrised, clocked successor to the 4-bit ripple adder with 7-segment decode.
- Accepts two WIDTH-bit operands and a carry-in via a valid/ready handshake, and registers the sum.
- Converts the sum to BCD with a sequential double-dabble engine, one shift per cycle.
- Drives a time-multiplexed, multi-digit, active-low common-anode 7-segment display.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- DIGITS, 3, number of display digits. Must satisfy 10^DIGITS > 2^(WIDTH+1)−1; any other value is an illegal configuration.
- REFRESH_DIV, 50000, clock cycles each digit is lit (≥1).
- BLANK_LZ, 1, when 1, leading zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands present.
- in_ready, output, 1, block idle; high exactly when state is IDLE.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in.
- sum, output, WIDTH, registered sum.
- cout, output, 1, registered carry-out.
- bcd, output, 4*DIGITS, registered BCD of {cout,sum}; digit 0 in bits [3:0].
- done, output, 1, one-cycle pulse when bcd is updated.
- disp_en, input, 1, display enable, active high.
- seg_n, output, 7, segments {g,f,e,d,c,b,a}, active low.
- an_n, output, DIGITS, digit anodes, active low, one-hot.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sum=0, cout=0, bcd=0, done=0.
  - Scan index=0, refresh counter=0.
  - Outputs recover on the first clock edge after release; no glitch requirements during reset.
- FSM states: IDLE → ADD → CONV → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - At an edge with in_valid=1, capture a, b, cin and go to ADD.
  - If in_valid=0, stay in IDLE.
- ADD:
  - 1 cycle. {cout,sum} ← a+b+cin, computed full-width with WIDTH+1 result bits.
  - Load the shift register with {cout,sum} and clear the BCD scratch. Go to CONV.
- CONV:
  - WIDTH+1 cycles.
  - Each cycle: add 3 to every scratch nibble ≥5, then shift left 1, MSB of the binary register entering scratch bit 0.
  - At the edge completing the final shift: bcd ← scratch, done ← 1, go to DONE.
- DONE:
  - 1 cycle, done=1. Next edge: done ← 0, go to IDLE.
- Latency:
  - done is high in the cycle starting WIDTH+2 edges after the accepting edge (10 for WIDTH=8).
  - Throughput is one operation per WIDTH+4 cycles.
  - in_valid is ignored outside IDLE; there is no queueing.
- sum/cout update at the end of ADD and hold until the next operation. bcd holds until the next done.
- Display scan:
  - The refresh counter counts 0..REFRESH_DIV−1. On wrap, the scan index advances 0..DIGITS−1, then wraps to 0.
  - The scan runs continuously, independent of the FSM and disp_en.
  - an_n = ~(1<<index) when disp_en=1; all ones when disp_en=0.
  - seg_n decodes bcd digit[index]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code = 1111111.
  - Leading-zero blanking: digit i>0 is blank (seg_n=1111111) when BLANK_LZ=1 and all digits ≥i are 0.
  - seg_n and an_n are registered and update together.
- bcd changing mid-scan takes effect on the next registered seg_n; no tearing protection.
- Reset mid-operation aborts the operation immediately; no done is produced.

Test Plan (WIDTH=8, DIGITS=3, REFRESH_DIV=4, BLANK_LZ=1):
- Reset release, disp_en=1 → in_ready=1, bcd=0x000, seg_n=1000000 on an_n=110; digits 1–2 blank; each digit lit 4 cycles.
- a=200, b=100, cin=1, one-cycle in_valid → sum=0x2D, cout=1; done pulses exactly 10 cycles after the accept edge; bcd=0x301; display shows 3,0,1.
- a=255, b=255, cin=1 → {cout,sum}=511, bcd=0x511; in_valid held high during busy is not re-accepted until in_ready returns; exactly one done per accepted handshake.
- a=7, b=2, cin=0 → bcd=0x009; digits 1 and 2 blanked; digit 0 shows 0010000.
- disp_en=0 for 20 cycles → an_n=111 throughout; scan index keeps advancing.
- rst_n pulsed low during CONV → all outputs reset asynchronously, no done; a subsequent operation completes normally.
